// File: rtl/mem_port_arbiter_if.sv
// One requester-side memory port: request/write fields from the requester, a one-cycle ack back.
// The requester drives the master view; the arbiter consumes the slave view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;

    modport master (output req, we, addr, wdata, input ack);
    modport slave  (input req, we, addr, wdata, output ack);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU on port 0, loader on port 1) in front of a single memory with fixed read latency.
// Serialises accesses through IDLE -> BUSY -> DONE, round-robin on ties, one-cycle ack per access.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2     // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave port0_if,
    mem_port_arbiter_if.slave port1_if,
    output logic [DW-1:0]     rdata_o,
    output logic              grant_o,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          grant_q, grant_d;
    logic          winner;

    // grant_q also serves as last_grant: the two are only ever written together.
    assign winner = (port0_if.req && port1_if.req) ? ~grant_q : port1_if.req;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant_d = grant_q;

        case (state_q)
            ST_IDLE: begin
                if (port0_if.req || port1_if.req) begin
                    grant_d = winner;
                    we_d    = winner ? port1_if.we    : port0_if.we;
                    addr_d  = winner ? port1_if.addr  : port0_if.addr;
                    wdata_d = winner ? port1_if.wdata : port0_if.wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
        end
    end

    // The first BUSY cycle is the only one where the freshly loaded count is still untouched.
    assign mem_en_o    = (state_q == ST_BUSY) && (cnt_q == CNT_LOAD);
    assign mem_we_o    = mem_en_o && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != ST_IDLE);

    assign port0_if.ack = (state_q == ST_DONE) && !grant_q;
    assign port1_if.ack = (state_q == ST_DONE) &&  grant_q;

endmodule
